// File: rtl/emitir_pin.sv
// PIN key emitter: replays a latched 4-digit PIN as timed key strobes (digit4 first).
// Optional terminator key is compiled in with EMITIR_PIN_ENTER_EN.
package emitir_pin_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
  } pinPac_t;
endpackage

module emitir_pin
  import emitir_pin_pkg::*;
#(
  parameter int         GAP_CYCLES = 2,
  parameter logic [3:0] ENTER_CODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  pinPac_t    pin_in,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, KEY, GAP, FINISH} state_t;

`ifdef EMITIR_PIN_ENTER_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] latch;
  logic [2:0]  idx;
  logic [3:0]  gap_cnt;

  logic [3:0] lat_digit [4];
  logic [2:0] nidx;
  logic [3:0] next_code;
  logic       next_bad;

  // lat_digit[0] is digit4 (oldest key), lat_digit[3] is digit1
  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    assign lat_digit[gi] = latch[15-4*gi -: 4];
  end

  always_comb begin
    nidx      = idx + 3'd1;
    next_code = lat_digit[nidx[1:0]];
    next_bad  = 1'b0;
    if (nidx == 3'd4) begin
      next_code = ENTER_CODE;
    end else if (next_code > 4'd9) begin
      next_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      latch     <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pin_in.status) begin
              latch <= {pin_in.digit4, pin_in.digit3, pin_in.digit2, pin_in.digit1};
              idx   <= '0;
              state <= KEY;
              // outputs are registered, so the first key is launched on the accepting edge
              if (pin_in.digit4 <= 4'd9) begin
                key_valid <= 1'b1;
                key_code  <= pin_in.digit4;
                busy      <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end else begin
              error <= 1'b1;
            end
          end
        end
        KEY: begin
          if (error) begin
            state <= IDLE;
          end else begin
            state   <= GAP;
            gap_cnt <= GAP_INIT;
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (idx == LAST_IDX) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            idx   <= nidx;
            state <= KEY;
            if (next_bad) begin
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              key_valid <= 1'b1;
              key_code  <= next_code;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emitir_pin.sv
// Directed bench for emitir_pin: per-cycle expectations derived from key period and gap length.
module tb_emitir_pin;
  import emitir_pin_pkg::*;

  localparam int G = 2;
`ifdef EMITIR_PIN_ENTER_EN
  localparam int NK = 5;
`else
  localparam int NK = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  pinPac_t    pin_in = '0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  emitir_pin #(.GAP_CYCLES(G), .ENTER_CODE(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .pin_in(pin_in),
    .key_valid(key_valid), .key_code(key_code), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic kv, input logic [3:0] kc,
                           input logic bz, input logic dn, input logic er);
    check({tag, "/key_valid"}, 32'(key_valid), 32'(kv));
    check({tag, "/key_code"},  32'(key_code),  32'(kc));
    check({tag, "/busy"},      32'(busy),      32'(bz));
    check({tag, "/done"},      32'(done),      32'(dn));
    check({tag, "/error"},     32'(error),     32'(er));
  endtask

  task automatic idle_check(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_all($sformatf("%s/idle%0d", name, c), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    $display("txn %s: idle for %0d cycles", name, ncyc);
  endtask

  // Start an emission and check every cycle; optionally disturb with start/pin changes, or abort by reset.
  task automatic run_pin(input string name, input logic [3:0] d4, input logic [3:0] d3,
                         input logic [3:0] d2, input logic [3:0] d1,
                         input int disturb_c, input int abort_c);
    logic [3:0] keys [5];
    int err_k, err_c, done_c, last_c, k, ph;
    logic kv, bz, dn, er;
    logic [3:0] kc;
    keys[0] = d4; keys[1] = d3; keys[2] = d2; keys[3] = d1; keys[4] = 4'hF;
    err_k = -1;
    for (int i = 3; i >= 0; i--) if (keys[i] > 4'd9) err_k = i;
    err_c  = (err_k >= 0) ? err_k * (G + 1) + 1 : -1;
    done_c = (err_k >= 0) ? -1 : NK * (G + 1) + 1;
    last_c = ((err_k >= 0) ? err_c : done_c) + 2;

    @(negedge clk);
    pin_in = '{status: 1'b1, digit4: d4, digit3: d3, digit2: d2, digit1: d1};
    start  = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check_all($sformatf("%s/abort", name), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        $display("txn %s: aborted by reset at cycle %0d", name, c);
        return;
      end
      k  = (c - 1) / (G + 1);
      ph = (c - 1) % (G + 1);
      kv = 1'b0; kc = 4'h0;
      if (ph == 0 && k < NK && (err_k < 0 || k < err_k)) begin
        kv = 1'b1;
        kc = keys[k];
      end
      bz = (done_c > 0 && c <= done_c) || (err_c > 0 && c < err_c);
      dn = (c == done_c);
      er = (c == err_c);
      check_all($sformatf("%s/c%0d", name, c), kv, kc, bz, dn, er);
      if (c == disturb_c) begin
        start  = 1'b1;
        pin_in = '{status: 1'b1, digit4: 4'd8, digit3: 4'd8, digit2: 4'd8, digit1: 4'd8};
      end
    end
    $display("txn %s: pin %0h%0h%0h%0h checked over %0d cycles", name, d4, d3, d2, d1, last_c);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    $display("txn reset: outputs checked while rst high before any clock edge");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_pin("basic", 4'd1, 4'd2, 4'd3, 4'd4, 0, 0);
    idle_check("after_basic", 1);
    run_pin("b2b_bounds", 4'd9, 4'd0, 4'd9, 4'd0, 0, 0);

    // refused request: status low
    @(negedge clk);
    pin_in = '{status: 1'b0, digit4: 4'd1, digit3: 4'd2, digit2: 4'd3, digit1: 4'd4};
    start  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_all($sformatf("nostatus/c%0d", c), 1'b0, 4'h0, 1'b0, 1'b0, c == 1);
    end
    $display("txn nostatus: error pulse expected at cycle 1 only");

    run_pin("bad_digit2", 4'd5, 4'd6, 4'hA, 4'd7, 0, 0);
    run_pin("bad_digit4", 4'hC, 4'd1, 4'd1, 4'd1, 0, 0);
    idle_check("after_bad", 2);
    run_pin("disturb", 4'd3, 4'd1, 4'd4, 4'd1, 3, 0);
    idle_check("after_disturb", 1);
    run_pin("abort", 4'd7, 4'd7, 4'd7, 4'd7, 0, 5);
    idle_check("after_abort", 4);
    run_pin("post_abort", 4'd9, 4'd8, 4'd7, 4'd6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
